// File: rtl/pdm_capture_sequencer_if.sv
// Control, decoder and stream signals of pdm_capture_sequencer.
// The irq signal exists only when PDM_CAPTURE_SEQUENCER_IRQ_EN is defined.
interface pdm_capture_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DIV_WIDTH  = 8,
  parameter int unsigned CNT_WIDTH  = 24
) ();

  logic                  ctrl_start;
  logic                  ctrl_stop;
  logic [DIV_WIDTH-1:0]  cfg_clk_div;
  logic [CNT_WIDTH-1:0]  cfg_num_samples;
  logic                  pdm_clk;
  logic                  pdm_sample_en;
  logic                  dec_enable;
  logic                  dec_valid;
  logic [DATA_WIDTH-1:0] dec_data;
  logic                  m_tvalid;
  logic                  m_tready;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tlast;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [CNT_WIDTH-1:0]  sample_count;
`ifdef PDM_CAPTURE_SEQUENCER_IRQ_EN
  logic                  irq;
`endif

  // Sequencer side.
  modport master (
`ifdef PDM_CAPTURE_SEQUENCER_IRQ_EN
    output irq,
`endif
    input  ctrl_start, ctrl_stop, cfg_clk_div, cfg_num_samples,
    input  dec_valid, dec_data, m_tready,
    output pdm_clk, pdm_sample_en, dec_enable,
    output m_tvalid, m_tdata, m_tlast,
    output busy, done, overflow, sample_count
  );

  // Register bank / decoder / stream sink side.
  modport slave (
`ifdef PDM_CAPTURE_SEQUENCER_IRQ_EN
    input  irq,
`endif
    output ctrl_start, ctrl_stop, cfg_clk_div, cfg_num_samples,
    output dec_valid, dec_data, m_tready,
    input  pdm_clk, pdm_sample_en, dec_enable,
    input  m_tvalid, m_tdata, m_tlast,
    input  busy, done, overflow, sample_count
  );

endinterface

// File: rtl/pdm_capture_sequencer.sv
// Sequences one PDM capture: bit clock, warm-up discard, sample buffering and block-framed stream.
// Optional irq output when PDM_CAPTURE_SEQUENCER_IRQ_EN is defined.
module pdm_capture_sequencer #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned DIV_WIDTH      = 8,
  parameter int unsigned CNT_WIDTH      = 24,
  parameter int unsigned BLOCK_LEN      = 256,
  parameter int unsigned WARMUP_SAMPLES = 64
) (
  input logic                     ACLK,
  input logic                     ARESET,
  pdm_capture_sequencer_if.master bus
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned BlkW  = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam int unsigned WarmW = $clog2(WARMUP_SAMPLES + 1);
  localparam int unsigned EntW  = DATA_WIDTH + 1;

  localparam logic [PtrW:0]    FifoFull = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [BlkW-1:0]  BlkLast  = BlkW'(BLOCK_LEN - 1);
  localparam logic [WarmW-1:0] WarmLast = WarmW'(WARMUP_SAMPLES - 1);

  typedef enum logic [1:0] {StIdle, StWarmup, StCapture, StDrain} state_e;

  state_e r_state, w_state_next;

  logic [DIV_WIDTH-1:0]  r_cfg_div;
  logic [CNT_WIDTH-1:0]  r_cfg_num;
  logic [DIV_WIDTH-1:0]  r_div_cnt;
  logic                  r_pdm_clk;
  logic                  r_sample_en;
  logic [WarmW-1:0]      r_warm_cnt;
  logic [CNT_WIDTH-1:0]  r_sample_cnt;
  logic [BlkW-1:0]       r_blk_cnt;
  logic                  r_done;
  logic                  r_overflow;

  logic [EntW-1:0]       r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]       r_wr_ptr;
  logic [PtrW-1:0]       r_rd_ptr;
  logic [PtrW:0]         r_fifo_cnt;

  logic                  w_start;
  logic                  w_run;
  logic                  w_run_next;
  logic                  w_warm_done;
  logic                  w_cap_valid;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [CNT_WIDTH-1:0]  w_cnt_plus1;
  logic [CNT_WIDTH-1:0]  w_cnt_inc;
  logic                  w_hit_num;
  logic                  w_last_flag;
  logic                  w_cap_end;
  logic                  w_drain_done;
  logic                  w_busy;
  logic                  w_dec_enable;
  logic [EntW-1:0]       w_head;

  assign w_start      = (r_state == StIdle) && bus.ctrl_start;
  assign w_run        = (r_state == StWarmup) || (r_state == StCapture);
  assign w_run_next   = (w_state_next == StWarmup) || (w_state_next == StCapture);
  assign w_warm_done  = (r_state == StWarmup) && bus.dec_valid && (r_warm_cnt == WarmLast);
  assign w_cap_valid  = (r_state == StCapture) && bus.dec_valid;

  // Full is taken from the registered count, so a same-cycle pop never makes room.
  assign w_full       = (r_fifo_cnt == FifoFull);
  assign w_empty      = (r_fifo_cnt == '0);
  assign w_push       = w_cap_valid && !w_full;
  assign w_pop        = !w_empty && bus.m_tready;

  assign w_cnt_plus1  = r_sample_cnt + CNT_WIDTH'(1);
  assign w_cnt_inc    = (&r_sample_cnt) ? r_sample_cnt : w_cnt_plus1;
  assign w_hit_num    = (r_cfg_num != '0) && (w_cnt_plus1 == r_cfg_num);
  assign w_last_flag  = (r_blk_cnt == BlkLast) || w_hit_num;
  assign w_cap_end    = w_cap_valid && w_hit_num;
  assign w_drain_done = (r_state == StDrain) && w_empty;

  // FSM: state register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (bus.ctrl_start) begin
          w_state_next = StWarmup;
        end
      end
      StWarmup: begin
        if (bus.ctrl_stop) begin
          w_state_next = StIdle;
        end else if (w_warm_done) begin
          w_state_next = StCapture;
        end
      end
      StCapture: begin
        if (bus.ctrl_stop || w_cap_end) begin
          w_state_next = StDrain;
        end
      end
      StDrain: begin
        if (w_empty) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FSM: state-decoded outputs.
  always_comb begin
    w_busy       = 1'b0;
    w_dec_enable = 1'b0;
    unique case (r_state)
      StIdle:    ;
      StWarmup:  begin w_busy = 1'b1; w_dec_enable = 1'b1; end
      StCapture: begin w_busy = 1'b1; w_dec_enable = 1'b1; end
      StDrain:   w_busy = 1'b1;
      default:   ;
    endcase
  end

  // Config latch and capture bookkeeping.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_cfg_div    <= '0;
      r_cfg_num    <= '0;
      r_warm_cnt   <= '0;
      r_sample_cnt <= '0;
      r_blk_cnt    <= '0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (w_start) begin
      r_cfg_div    <= bus.cfg_clk_div;
      r_cfg_num    <= bus.cfg_num_samples;
      r_warm_cnt   <= '0;
      r_sample_cnt <= '0;
      r_blk_cnt    <= '0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if ((r_state == StWarmup) && bus.dec_valid) begin
        r_warm_cnt <= r_warm_cnt + WarmW'(1);
      end
      if (w_cap_valid) begin
        r_sample_cnt <= w_cnt_inc;
        r_blk_cnt    <= (r_blk_cnt == BlkLast) ? '0 : r_blk_cnt + BlkW'(1);
        if (w_full) begin
          r_overflow <= 1'b1;
        end
      end
      if (w_drain_done) begin
        r_done <= 1'b1;
      end
    end
  end

  // PDM clock divider; idle low and cleared on both the entry and the exit edge of a run.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_div_cnt   <= '0;
      r_pdm_clk   <= 1'b0;
      r_sample_en <= 1'b0;
    end else if (!w_run || !w_run_next) begin
      r_div_cnt   <= '0;
      r_pdm_clk   <= 1'b0;
      r_sample_en <= 1'b0;
    end else if (r_div_cnt == r_cfg_div) begin
      r_div_cnt   <= '0;
      r_pdm_clk   <= ~r_pdm_clk;
      r_sample_en <= ~r_pdm_clk;
    end else begin
      r_div_cnt   <= r_div_cnt + DIV_WIDTH'(1);
      r_sample_en <= 1'b0;
    end
  end

  // Output FIFO pointers and occupancy.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + (PtrW + 1)'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - (PtrW + 1)'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // Storage array carries no reset; the read side is masked while empty.
  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_last_flag, bus.dec_data};
    end
  end

  assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

`ifdef PDM_CAPTURE_SEQUENCER_IRQ_EN
  logic r_irq;
  logic w_done_rise;
  logic w_ovf_rise;

  assign w_done_rise = w_drain_done && !r_done;
  assign w_ovf_rise  = w_cap_valid && w_full && !r_overflow && !w_start;

  // Registered alongside done/overflow so the pulse lines up with their rising cycle.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= w_done_rise || w_ovf_rise;
    end
  end

  assign bus.irq = r_irq;
`endif

  assign bus.pdm_clk       = r_pdm_clk;
  assign bus.pdm_sample_en = r_sample_en;
  assign bus.dec_enable    = w_dec_enable;
  assign bus.busy          = w_busy;
  assign bus.done          = r_done;
  assign bus.overflow      = r_overflow;
  assign bus.sample_count  = r_sample_cnt;
  assign bus.m_tvalid      = !w_empty;
  assign bus.m_tdata       = w_head[DATA_WIDTH-1:0];
  assign bus.m_tlast       = w_head[DATA_WIDTH];

endmodule
